// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame geometry and a 2-of-3 vote helper.
package uart_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'b00;
    localparam state_t START = 2'b01;
    localparam state_t DATA  = 2'b10;
    localparam state_t STOP  = 2'b11;

    localparam int DEFAULT_CLKS_PER_BIT = 10416;
    localparam int DATA_BITS            = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus falling-edge detect.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_line,
    output logic s2,
    output logic fall_edge
);

    logic s1_r;
    logic s2_r;
    logic s_prev_r;

    // Resync chain; idles high so reset cannot fake a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r     <= 1'b1;
            s2_r     <= 1'b1;
            s_prev_r <= 1'b1;
        end else begin
            s1_r     <= rx_line;
            s2_r     <= s1_r;
            s_prev_r <= s2_r;
        end
    end

    assign s2        = s2_r;
    assign fall_edge = s_prev_r & ~s2_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, oversampled by the system clock.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote at every sample point.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RsRx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    state_t                 state_r;
    state_t                 state_next;
    logic [CNT_W-1:0]       clk_cnt_r;
    logic [2:0]             bit_idx_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   s2_s;
    logic                   fall_edge_s;
    logic                   tick_s;
    logic                   bit_s;
    logic [DATA_BITS-1:0]   rx_data_next;
    logic                   rx_valid_next;
    logic                   frame_err_next;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .rx_line   (RsRx),
        .s2        (s2_s),
        .fall_edge (fall_edge_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote_hist_r;

    // Holds s2 from the two cycles before the current one (T-2, T-1)
    always_ff @(posedge clk) begin
        if (rst) begin
            vote_hist_r <= 2'b11;
        end else begin
            vote_hist_r <= {vote_hist_r[0], s2_s};
        end
    end

    assign bit_s = majority3(vote_hist_r[1], vote_hist_r[0], s2_s);
`else
    assign bit_s = s2_s;
`endif

    // Sample point: mid start bit in START, one full bit later elsewhere
    always_comb begin
        if (state_r == START) begin
            tick_s = (clk_cnt_r == HALF_CNT);
        end else begin
            tick_s = (clk_cnt_r == LAST_CNT);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE: begin
                if (fall_edge_s) state_next = START;
                else             state_next = IDLE;
            end
            START: begin
                if (tick_s) state_next = bit_s ? IDLE : DATA;
                else        state_next = START;
            end
            DATA: begin
                if (tick_s && (bit_idx_r == LAST_BIT)) state_next = STOP;
                else                                  state_next = DATA;
            end
            STOP: begin
                if (tick_s) state_next = IDLE;
                else        state_next = STOP;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output next values; only the stop-bit decision touches them
    always_comb begin
        rx_data_next   = rx_data;
        rx_valid_next  = 1'b0;
        frame_err_next = frame_err;
        if ((state_r == STOP) && tick_s) begin
            if (bit_s) begin
                rx_data_next   = shift_r;
                rx_valid_next  = 1'b1;
                frame_err_next = 1'b0;
            end else begin
                frame_err_next = 1'b1;
            end
        end else begin
            rx_valid_next = 1'b0;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_data   <= rx_data_next;
            rx_valid  <= rx_valid_next;
            frame_err <= frame_err_next;
            busy      <= (state_next != IDLE);
        end
    end

    // Bit-clock counter, bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt_r <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    clk_cnt_r <= '0;
                    bit_idx_r <= 3'd0;
                end
                START, STOP: begin
                    bit_idx_r <= 3'd0;
                    if (tick_s) clk_cnt_r <= '0;
                    else        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                end
                DATA: begin
                    if (tick_s) begin
                        clk_cnt_r <= '0;
                        bit_idx_r <= bit_idx_r + 3'd1;
                        shift_r   <= {bit_s, shift_r[DATA_BITS-1:1]};
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    clk_cnt_r <= '0;
                    bit_idx_r <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; follows UART_RX_MAJORITY_EN if defined.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       RsRx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int         total;
    int         bad;
    int         valid_cnt;
    int         v0;
    logic [7:0] data_log [0:31];
    logic [7:0] glitch_exp;

    uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .RsRx      (RsRx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Log every rx_valid cycle; a stretched pulse shows up as an extra entry
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            data_log[valid_cnt[4:0]] = rx_data;
            valid_cnt = valid_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        RsRx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame; optional one-clock glitch at a bit's sample point or rst pulse mid-bit
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int glitch_bit, input int rst_bit);
        RsRx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RsRx = b[i];
            if (i == glitch_bit) begin
                repeat (CPB / 2) @(negedge clk);
                RsRx = ~b[i];
                @(negedge clk);
                RsRx = b[i];
                repeat (CPB / 2 - 1) @(negedge clk);
            end else if (i == rst_bit) begin
                repeat (CPB / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                RsRx = 1'b1;
                return;
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        RsRx = stop_bit;
        repeat (CPB) @(negedge clk);
        RsRx = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        RsRx = 1'b1;
        total = 0;
        bad = 0;
        valid_cnt = 0;
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'hF0;
`else
        glitch_exp = 8'hF8;
`endif

        repeat (3) @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        idle_cycles(8);

        // Single good frame
        send_frame(8'hA5, 1'b1, -1, -1);
        idle_cycles(4);
        check("a5_valid_cnt", valid_cnt, 1);
        check("a5_logged", data_log[0], 8'hA5);
        check("a5_rx_data", rx_data, 8'hA5);
        check("a5_frame_err", frame_err, 1'b0);
        check("a5_busy", busy, 1'b0);

        // Back-to-back frames, single stop bit each
        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        idle_cycles(4);
        check("b2b_valid_cnt", valid_cnt, 3);
        check("b2b_first", data_log[1], 8'h00);
        check("b2b_second", data_log[2], 8'hFF);
        check("b2b_frame_err", frame_err, 1'b0);

        // 4-clock low glitch on an idle line
        RsRx = 1'b0;
        repeat (4) @(negedge clk);
        RsRx = 1'b1;
        check("glitch_busy_mid", busy, 1'b1);
        idle_cycles(30);
        check("glitch_valid_cnt", valid_cnt, 3);
        check("glitch_frame_err", frame_err, 1'b0);
        check("glitch_busy_after", busy, 1'b0);
        check("glitch_rx_data", rx_data, 8'hFF);

        // Bad stop bit followed by a 3-bit-time break
        send_frame(8'h3C, 1'b0, -1, -1);
        RsRx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("ferr_frame_err", frame_err, 1'b1);
        check("ferr_rx_data", rx_data, 8'hFF);
        check("ferr_valid_cnt", valid_cnt, 3);
        check("ferr_no_retrigger", busy, 1'b0);
        idle_cycles(20);
        send_frame(8'h81, 1'b1, -1, -1);
        idle_cycles(4);
        check("recover_valid_cnt", valid_cnt, 4);
        check("recover_rx_data", rx_data, 8'h81);
        check("recover_frame_err", frame_err, 1'b0);

        // Reset pulse during data bit 4
        send_frame(8'h55, 1'b1, -1, 4);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        idle_cycles(3 * CPB);
        check("rst_no_valid", valid_cnt, 4);
        send_frame(8'h55, 1'b1, -1, -1);
        idle_cycles(4);
        check("post_rst_valid_cnt", valid_cnt, 5);
        check("post_rst_rx_data", rx_data, 8'h55);

        // One-clock flip exactly at the bit-3 sample point
        send_frame(8'hF0, 1'b1, 3, -1);
        idle_cycles(4);
        check("vote_valid_cnt", valid_cnt, 6);
        check("vote_rx_data", rx_data, glitch_exp);
        check("vote_frame_err", frame_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: the link-partner stage that consumes the serial stream produced by our UART transmitter (RsTx → RsRx on the Basys3 USB-UART bridge).
- Oversamples the line with the 100 MHz system clock.
- Delivers one received byte plus a one-cycle valid strobe to the LED and display logic.
- Reports framing errors and discards false start bits.

Parameters:
- CLKS_PER_BIT, 10416, system clocks per bit (100 MHz / 9600 baud). Must be ≥ 8.
- CNT_W, 14, bit-clock counter width. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock, 100 MHz, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- RsRx  input  1  asynchronous serial line; idles high
- rx_data  output  8  last good byte received, LSB first on the wire
- rx_valid  output  1  one-cycle pulse when rx_data updates
- frame_err  output  1  high when the last frame had a bad stop bit
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, busy=0, state=IDLE, counters=0. Both synchronizer flops reset to 1.
- Synchronizer: RsRx goes through a 2-flop synchronizer (s1, s2). A third flop, s_prev, is used for edge detection. All decisions use s2.
- States: IDLE, START, DATA, STOP.
- IDLE: waits for a falling edge (s_prev=1, s2=0), then enters START with clk_cnt=0.
  - A line held low (break) never retriggers, because a new edge is required.
- START: counts to HALF = CLKS_PER_BIT/2 - 1 (integer division; 5207 at default).
  - At HALF: s2=0 → DATA with clk_cnt=0 and bit_idx=0.
  - At HALF: s2=1 → IDLE (glitch rejected; no flags change).
- DATA: counts to CLKS_PER_BIT-1, then samples.
  - Sampled bit shifts into shift_reg[7]; shift_reg shifts right, so the LSB arrives first.
  - bit_idx increments. After the sample with bit_idx=7 → STOP.
  - clk_cnt wraps to 0 on every sample.
- STOP: counts to CLKS_PER_BIT-1, then samples.
  - s2=1: rx_data<=shift_reg, rx_valid=1 for exactly one cycle, frame_err<=0.
  - s2=0: rx_data unchanged, no rx_valid, frame_err<=1.
  - Either case → IDLE on the same edge.
- frame_err is sticky until the next good stop bit or rst.
- Latency: rx_valid rises about 9.5 bit times after the wire falling edge, plus 2–3 clk of synchronizer delay.
- Back-to-back frames: the next start edge is accepted from the first IDLE cycle. There is no idle-gap requirement beyond the stop bit's second half.
- rst asserted mid-frame: everything returns to reset values on the next edge. The partial byte is discarded and no rx_valid is produced.
- There is no flow control and no input buffer. The consumer must capture rx_data on rx_valid.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each START, DATA and STOP decision uses a 2-of-3 majority vote of s2 at sample points T-2, T-1 and T, where T is HALF or CLKS_PER_BIT-1. A single-cycle glitch at T cannot corrupt a bit or abort a start.
- Not defined: single sample of s2 at T. No vote registers are synthesized.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11);
  - DEFAULT_CLKS_PER_BIT=10416;
  - DATA_BITS=8, shared with the transmitter.
- One natural sub-module: uart_rx_sync, the 2-flop synchronizer plus edge detector. Outputs: s2 and fall_edge.
- The FSM, counters and shift register stay in uart_rx.

Test Plan:
- CLKS_PER_BIT=16, send 8'hA5 as 8N1 → exactly one rx_valid pulse, rx_data=8'hA5, frame_err=0, busy low afterwards.
- Send 8'h00 then 8'hFF back-to-back with a single stop bit each → two rx_valid pulses, values 8'h00 then 8'hFF, no frame_err.
- Low pulse of 4 clk (shorter than HALF) on an idle line → START aborts to IDLE; no rx_valid, frame_err unchanged.
- Send 8'h3C with stop bit forced 0, then the line held low for 3 bit times → frame_err=1, rx_data keeps its previous value, no rx_valid, no retrigger. Then send 8'h81 correctly → rx_valid, rx_data=8'h81, frame_err=0.
- Assert rst for 1 cycle during DATA bit 4 of 8'h55 → all outputs return to reset values, no rx_valid. The next full frame 8'h55 is received correctly.
- With UART_RX_MAJORITY_EN defined, flip s2 for 1 clk exactly at the bit-3 sample point of 8'hF0 → rx_data=8'hF0. Without the macro, the same stimulus → rx_data=8'hF8.
